// File: rtl/pll_lock_supervisor.sv
// PLL lock supervisor: sequences the PLL reset, qualifies lock as stable,
// releases the core system reset, retries on lock timeout, latches failure
// after a bounded number of retries and relocks on loss of lock.
module pll_lock_supervisor #(
  parameter int RST_HOLD_CYCLES     = 1000,
  parameter int LOCK_TIMEOUT_CYCLES = 500000,
  parameter int LOCK_STABLE_CYCLES  = 5000,
  parameter int MAX_RETRIES         = 7,
  parameter int SYNC_STAGES         = 2,
  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1)
) (
  input  logic          refclk,
  input  logic          rst_n,
  input  logic          pll_locked,
  input  logic          force_relock,
  output logic          pll_rst,
  output logic          sys_rst_n,
  output logic          sys_ready,
  output logic          lock_fail,
  output logic [RW-1:0] retry_count,
  output logic [7:0]    loss_count,
  output logic [2:0]    state
);

  // Shared dwell counter only has to reach the longest terminal count.
  localparam int CNT_MAX_I = (LOCK_TIMEOUT_CYCLES > LOCK_STABLE_CYCLES) ?
                             ((LOCK_TIMEOUT_CYCLES > RST_HOLD_CYCLES) ? LOCK_TIMEOUT_CYCLES : RST_HOLD_CYCLES) :
                             ((LOCK_STABLE_CYCLES  > RST_HOLD_CYCLES) ? LOCK_STABLE_CYCLES  : RST_HOLD_CYCLES);
  localparam int CNT_W = $clog2(CNT_MAX_I + 1);

  localparam logic [CNT_W-1:0] HOLD_LAST    = CNT_W'(RST_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_SAT      = CNT_W'(CNT_MAX_I);
  localparam logic [RW-1:0]    RETRY_LIMIT  = RW'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_RESET_PLL = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RUN       = 3'd3,
    S_FAIL      = 3'd4
  } state_e;

  logic [SYNC_STAGES-1:0] sync_p;
  logic                   locked_s;
  logic [2:0]             state_q;
  logic [CNT_W-1:0]       cnt_q;
  state_e                 state_d;
  logic [RW-1:0]          retry_d;
  logic                   retry_req;
  logic                   entry;
  logic                   loss_inc;

  // pll_locked is asynchronous to refclk: resynchronise before any use.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p <= '0;
    end else begin
      sync_p <= {sync_p[SYNC_STAGES-2:0], pll_locked};
    end
  end

  assign locked_s = sync_p[SYNC_STAGES-1];
  assign state    = state_q;

  // Next-state, retry bookkeeping and loss detection.
  always_comb begin
    state_d   = S_RESET_PLL;
    retry_d   = retry_count;
    retry_req = 1'b0;
    loss_inc  = 1'b0;
    if (force_relock) begin
      state_d = S_RESET_PLL;
      retry_d = '0;
    end else begin
      case (state_q)
        S_RESET_PLL: state_d = (cnt_q == HOLD_LAST) ? S_WAIT_LOCK : S_RESET_PLL;
        S_WAIT_LOCK: begin
          state_d = S_WAIT_LOCK;
          if (locked_s)                   state_d   = S_STABLE;
          else if (cnt_q == TIMEOUT_LAST) retry_req = 1'b1;
        end
        S_STABLE: begin
          state_d = S_STABLE;
          // A drop coinciding with the terminal count still counts as a drop.
          if (!locked_s)                 retry_req = 1'b1;
          else if (cnt_q == STABLE_LAST) state_d   = S_RUN;
        end
        S_RUN: begin
          state_d = S_RUN;
          if (!locked_s) begin
            state_d  = S_RESET_PLL;
            loss_inc = 1'b1;
          end
        end
        S_FAIL:  state_d = S_FAIL;
        default: state_d = S_RESET_PLL;
      endcase
      if (retry_req) begin
        if (retry_count == RETRY_LIMIT) begin
          state_d = S_FAIL;
        end else begin
          state_d = S_RESET_PLL;
          retry_d = retry_count + RW'(1);
        end
      end
    end
    if (state_d == S_RUN) retry_d = '0;
  end

  // A forced relock restarts timing even when the state itself does not change.
  assign entry = force_relock || (3'(state_d) != state_q);

  // State, dwell counter and outputs decoded from next state.
  always_ff @(posedge refclk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_RESET_PLL;
      cnt_q       <= '0;
      pll_rst     <= 1'b1;
      sys_rst_n   <= 1'b0;
      sys_ready   <= 1'b0;
      lock_fail   <= 1'b0;
      retry_count <= '0;
      loss_count  <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= entry ? '0 : ((cnt_q == CNT_SAT) ? cnt_q : cnt_q + CNT_W'(1));
      pll_rst     <= (state_d == S_RESET_PLL) || (state_d == S_FAIL);
      sys_rst_n   <= (state_d == S_RUN);
      sys_ready   <= (state_d == S_RUN);
      lock_fail   <= (state_d == S_FAIL);
      retry_count <= retry_d;
      if (loss_inc && (loss_count != 8'hFF)) loss_count <= loss_count + 8'd1;
    end
  end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Testbench for pll_lock_supervisor: directed scenarios plus randomized lock
// activity, every cycle compared against a phase/dwell-time reference model.
module tb_pll_lock_supervisor;

  localparam int RST_HOLD = 4;
  localparam int TIMEOUT  = 20;
  localparam int STABLE   = 8;
  localparam int MAXR     = 2;
  localparam int SYNC     = 2;

  logic       refclk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_locked = 1'b0;
  logic       force_relock = 1'b0;
  logic       pll_rst, sys_rst_n, sys_ready, lock_fail;
  logic [1:0] retry_count;
  logic [7:0] loss_count;
  logic [2:0] state;

  pll_lock_supervisor #(
    .RST_HOLD_CYCLES(RST_HOLD), .LOCK_TIMEOUT_CYCLES(TIMEOUT),
    .LOCK_STABLE_CYCLES(STABLE), .MAX_RETRIES(MAXR), .SYNC_STAGES(SYNC)
  ) dut (
    .refclk(refclk), .rst_n(rst_n), .pll_locked(pll_locked),
    .force_relock(force_relock), .pll_rst(pll_rst), .sys_rst_n(sys_rst_n),
    .sys_ready(sys_ready), .lock_fail(lock_fail), .retry_count(retry_count),
    .loss_count(loss_count), .state(state)
  );

  always #5 refclk = ~refclk;

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: observed %0h expected %0h", tag, got, exp);
  endtask

  // Reference model: phase of the lock sequence, time spent in it, and the
  // history of pll_locked samples (newest first) standing in for the synchroniser.
  int m_phase, m_dwell, m_retry, m_loss;
  bit hist[$];

  function automatic void m_reset();
    m_phase = 0; m_dwell = 0; m_retry = 0; m_loss = 0;
    hist.delete();
    for (int i = 0; i < SYNC; i++) hist.push_back(1'b0);
  endfunction

  function automatic void m_step(input bit lk, input bit frc);
    bit ls;
    int nxt;
    bit give_up;
    ls = hist[SYNC-1];
    hist.push_front(lk);
    void'(hist.pop_back());
    nxt = m_phase;
    give_up = 1'b0;
    if (frc) begin
      nxt = 0; m_retry = 0;
    end else begin
      case (m_phase)
        0: if (m_dwell == RST_HOLD - 1) nxt = 1;
        1: if (ls) nxt = 2; else if (m_dwell == TIMEOUT - 1) give_up = 1'b1;
        2: if (!ls) give_up = 1'b1; else if (m_dwell == STABLE - 1) nxt = 3;
        3: if (!ls) begin nxt = 0; if (m_loss < 255) m_loss++; end
        4: nxt = 4;
        default: nxt = 0;
      endcase
    end
    if (give_up) begin
      if (m_retry == MAXR) nxt = 4;
      else begin m_retry++; nxt = 0; end
    end
    if (nxt == 3) m_retry = 0;
    m_dwell = (frc || nxt != m_phase) ? 0 : m_dwell + 1;
    m_phase = nxt;
  endfunction

  function automatic logic [16:0] exp_vec();
    logic [2:0] ph;
    logic [1:0] rc;
    logic [7:0] lc;
    ph = 3'(m_phase); rc = 2'(m_retry); lc = 8'(m_loss);
    return {(m_phase == 0 || m_phase == 4), (m_phase == 3), (m_phase == 3),
            (m_phase == 4), rc, lc, ph};
  endfunction

  function automatic logic [16:0] dut_vec();
    return {pll_rst, sys_rst_n, sys_ready, lock_fail, retry_count, loss_count, state};
  endfunction

  // One refclk cycle: model advances on the edge, outputs compared on the falling edge.
  task automatic tick(input string tag);
    @(posedge refclk);
    if (!rst_n) m_reset();
    else m_step(pll_locked, force_relock);
    @(negedge refclk);
    chk(tag, dut_vec(), exp_vec());
  endtask

  task automatic pulse_force(input string tag);
    force_relock = 1'b1;
    tick(tag);
    force_relock = 1'b0;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int hold;
    bit rose;
    m_reset();

    // Reset state
    repeat (3) tick("reset");
    chk("reset_outputs", dut_vec(), 17'h10000);

    // 1. Normal lock
    rst_n = 1'b1;
    n = 0;
    while (pll_rst !== 1'b0 && n < 100) begin tick("t1_hold"); n++; end
    chk("t1_pll_rst_len", n, RST_HOLD);
    repeat (2) tick("t1_wait");
    pll_locked = 1'b1;
    n = 0;
    while (state !== 3'd2 && n < 100) begin tick("t1_sync"); n++; end
    chk("t1_lock_latency", n, SYNC + 1);
    n = 0;
    while (sys_rst_n !== 1'b1 && n < 100) begin tick("t1_stable"); n++; end
    chk("t1_stable_len", n, STABLE);
    chk("t1_ready", {sys_ready, retry_count, loss_count}, {1'b1, 2'd0, 8'd0});

    // 2. Timeout and retries
    pll_locked = 1'b0;
    pulse_force("t2_force");
    for (int k = 0; k <= MAXR; k++) begin
      chk("t2_retry_count", retry_count, k);
      n = 0;
      while (pll_rst === 1'b1 && n < 100) begin tick("t2_high"); n++; end
      chk("t2_pulse_len", n, RST_HOLD);
      n = 0;
      while (pll_rst === 1'b0 && n < 100) begin tick("t2_low"); n++; end
      chk("t2_gap_len", n, TIMEOUT);
    end
    chk("t2_fail", {state, lock_fail, pll_rst, sys_rst_n}, {3'd4, 1'b1, 1'b1, 1'b0});
    repeat (10) tick("t2_fail_hold");
    chk("t2_fail_sticky", {state, lock_fail}, {3'd4, 1'b1});

    // 3. Recovery from FAIL
    pll_locked = 1'b1;
    repeat (3) tick("t3_pre");
    pulse_force("t3_force");
    chk("t3_cleared", {lock_fail, retry_count}, {1'b0, 2'd0});
    n = 0;
    while (sys_ready !== 1'b1 && n < 100) begin tick("t3_relock"); n++; end
    chk("t3_run", sys_ready, 1'b1);

    // 4. Stable glitch at count 5 (drop reaches the FSM on the terminal count)
    pulse_force("t4_force");
    n = 0;
    while (state !== 3'd2 && n < 100) begin tick("t4_to_stable"); n++; end
    chk("t4_in_stable", state, 3'd2);
    repeat (5) tick("t4_count");
    rose = 1'b0;
    pll_locked = 1'b0;
    tick("t4_glitch"); rose |= sys_rst_n;
    tick("t4_glitch"); rose |= sys_rst_n;
    pll_locked = 1'b1;
    n = 0;
    while (state !== 3'd0 && n < 10) begin tick("t4_drop"); rose |= sys_rst_n; n++; end
    chk("t4_retry", {state, retry_count}, {3'd0, 2'd1});
    chk("t4_no_release", rose, 1'b0);
    n = 0;
    while (sys_ready !== 1'b1 && n < 100) begin tick("t4_relock"); n++; end
    chk("t4_run", {sys_ready, retry_count}, {1'b1, 2'd0});

    // 5. Loss in RUN, then saturation of the loss counter
    pll_locked = 1'b0;
    n = 0;
    while (sys_rst_n !== 1'b0 && n < 10) begin tick("t5_loss"); n++; end
    chk("t5_loss_latency", n, SYNC + 1);
    chk("t5_loss_count", {loss_count, retry_count}, {8'd1, 2'd0});
    for (int i = 0; i < 299; i++) begin
      pll_locked = 1'b1;
      n = 0;
      while (sys_ready !== 1'b1 && n < 100) begin tick("t5_relock"); n++; end
      repeat ($urandom_range(0, 3)) tick("t5_dwell");
      pll_locked = 1'b0;
      n = 0;
      while (sys_rst_n !== 1'b0 && n < 10) begin tick("t5_drop"); n++; end
    end
    chk("t5_saturated", loss_count, 8'd255);

    // Randomized lock activity with occasional forced relocks
    hold = 0;
    for (int i = 0; i < 1500; i++) begin
      if (hold == 0) begin
        pll_locked = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 25);
      end
      hold--;
      force_relock = ($urandom_range(0, 99) == 0);
      tick("rand");
    end
    force_relock = 1'b0;

    // 6. Asynchronous reset in the middle of WAIT_LOCK
    pll_locked = 1'b0;
    pulse_force("t6_force");
    n = 0;
    while (state !== 3'd1 && n < 20) begin tick("t6_to_wait"); n++; end
    repeat (7) tick("t6_count");
    #1 rst_n = 1'b0;
    #1;
    chk("t6_async_state", state, 3'd0);
    chk("t6_async_ctl", {pll_rst, sys_rst_n, sys_ready, lock_fail}, 4'b1000);
    chk("t6_async_counts", {retry_count, loss_count}, 10'd0);
    m_reset();
    repeat (2) tick("t6_in_reset");
    rst_n = 1'b1;
    pll_locked = 1'b1;
    n = 0;
    while (sys_ready !== 1'b1 && n < 100) begin tick("t6_relock"); n++; end
    chk("t6_run", sys_ready, 1'b1);

    // Illegal state encoding recovers to RESET_PLL on the next edge
    force dut.state_q = 3'd6;
    m_phase = 6;
    #1 release dut.state_q;
    tick("illegal");
    chk("illegal_recover", {state, pll_rst, sys_rst_n}, {3'd0, 1'b1, 1'b0});
    repeat (20) tick("post_illegal");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Supervises the main clock PLL from the reference-clock side: drives the PLL reset, waits for lock, and qualifies lock as stable. Only then does it release the system reset for the core clock domains. It retries on lock timeout and declares failure after a bounded number of retries. On loss of lock it drops system reset and relocks. It sits at top level between the 50 MHz board clock, the PLL rst/locked pins and the core reset tree.

Parameters:
RST_HOLD_CYCLES, 1000, refclk cycles pll_rst is held high per attempt (20 us at 50 MHz)
LOCK_TIMEOUT_CYCLES, 500000, refclk cycles allowed in WAIT_LOCK before retry (10 ms)
LOCK_STABLE_CYCLES, 5000, refclk cycles locked must stay high before release (100 us)
MAX_RETRIES, 7, retries after the first attempt before FAIL; retry_count width = clog2(MAX_RETRIES+1)
SYNC_STAGES, 2, flops in the pll_locked synchroniser (min 2)

Ports:
refclk        in   1   board reference clock, sole clock
rst_n         in   1   asynchronous active-low reset
pll_locked    in   1   PLL lock indicator, asynchronous to refclk
force_relock  in   1   single-cycle request to restart the lock sequence
pll_rst       out  1   active-high PLL reset
sys_rst_n     out  1   active-low system reset to core domains
sys_ready     out  1   high while in RUN
lock_fail     out  1   sticky failure flag
retry_count   out  RW  retries used in the current sequence
loss_count    out  8   saturating count of lock losses while in RUN
state         out  3   current state encoding, for debug

Behaviour:
- One shared cycle counter, cleared on every state entry. All outputs are registered.
- Outputs are decoded from next-state, so each output changes on the same edge as the state transition.
- Reset (rst_n low): state=RESET_PLL, counter=0, pll_rst=1, sys_rst_n=0, sys_ready=0, lock_fail=0, retry_count=0, loss_count=0. The synchroniser flops are cleared to 0.
- locked_s is pll_locked after SYNC_STAGES flops. The raw input is never used directly.
- States and encodings: RESET_PLL=0, WAIT_LOCK=1, STABLE=2, RUN=3, FAIL=4. Encodings 5 to 7 recover to RESET_PLL.
- RESET_PLL: pll_rst=1, sys_rst_n=0. When counter==RST_HOLD_CYCLES-1, go to WAIT_LOCK.
- WAIT_LOCK: pll_rst=0. If locked_s=1, go to STABLE. Otherwise, when counter==LOCK_TIMEOUT_CYCLES-1, apply the retry rule.
- Retry rule: if retry_count==MAX_RETRIES, go to FAIL. Otherwise increment retry_count and go to RESET_PLL.
- STABLE: pll_rst=0. If locked_s=0, apply the retry rule. Otherwise, when counter==LOCK_STABLE_CYCLES-1, go to RUN.
- If locked_s falls on the same cycle the counter reaches terminal in STABLE, the drop wins.
- RUN: sys_rst_n=1, sys_ready=1, retry_count cleared on entry.
- RUN, on locked_s=0: go to RESET_PLL. sys_rst_n=0 and sys_ready=0 on the same edge. loss_count increments, saturating at 255. retry_count stays 0.
- FAIL: pll_rst=1, sys_rst_n=0, lock_fail=1. Stays in FAIL until force_relock or rst_n.
- force_relock=1 has the highest priority in any state. Next state is RESET_PLL, retry_count=0, lock_fail=0. loss_count is unchanged, and a force from RUN is not counted as a loss.
- Latency from a pll_locked edge to the state change is SYNC_STAGES+1 refclk edges.
- rst_n asserted mid-sequence returns everything to reset values immediately (asynchronously). Deassertion is consumed synchronously; no other reset path exists.
- sys_rst_n never rises except on entry to RUN. Between rst_n deassert and RUN there are at least RST_HOLD_CYCLES+LOCK_STABLE_CYCLES cycles.

Test Plan:
Bench parameters: RST_HOLD=4, TIMEOUT=20, STABLE=8, MAX_RETRIES=2, SYNC=2.
1. Normal lock. Release rst_n; raise pll_locked 3 cycles after pll_rst falls -> pll_rst high exactly 4 cycles; sys_rst_n rises 8 cycles after state=STABLE; sys_ready=1, retry_count=0, loss_count=0.
2. Timeout and retries. Hold pll_locked low -> 3 pll_rst pulses of 4 cycles each, each separated by 20 cycles low; retry_count counts 0,1,2; then state=FAIL, lock_fail=1, pll_rst stays 1, sys_rst_n stays 0.
3. Recovery from FAIL. From FAIL, pulse force_relock while pll_locked=1 -> lock_fail clears next edge; retry_count=0; sequence reaches RUN.
4. Stable glitch. In STABLE, drop pll_locked for 2 cycles at count 5 -> retry_count=1, back to RESET_PLL; sys_rst_n never rises during the glitch.
5. Loss in RUN. In RUN, drop pll_locked -> sys_rst_n=0 exactly 3 edges later; loss_count=1. Repeat 300 losses -> loss_count saturates at 255.
6. Async reset mid-sequence. Assert rst_n during WAIT_LOCK mid-count -> all outputs return to reset values without a clock edge. Also verify illegal state 6 forced by the bench -> RESET_PLL next edge.
